alu_op_sequencer: RTL

//   Issuing side of the ALU interface: accepts one decoded operation (ALUOp, funct, A, B) per

---
 rtl/alu_op_sequencer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_op_sequencer.sv
// ============================================================================
// Module      : alu_op_sequencer
// Description : Issues decoded ops to a 4-function ALU; builds SLT from SUB and
//               MULT as a WIDTH-cycle shift-add over ALU ADD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_op_sequencer #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_aluop,
    input  logic [5:0]       in_funct,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] alu_op1,
    output logic [WIDTH-1:0] alu_op2,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err
);

    localparam logic [3:0] C_AND = 4'b0000;
    localparam logic [3:0] C_OR  = 4'b0001;
    localparam logic [3:0] C_ADD = 4'b0010;
    localparam logic [3:0] C_SUB = 4'b0110;
    localparam int         CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MUL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [3:0]        r_ctrl;
    logic              r_slt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_res_data;
    logic              r_res_zero;
    logic              r_res_err;

    logic              w_accept;
    logic              w_legal;
    logic              w_is_mul;
    logic              w_is_slt;
    logic [3:0]        w_ctrl;
    logic              w_ovf;
    logic              w_lt;

    assign w_accept  = in_valid & in_ready;
    assign in_ready  = (r_state == S_IDLE);
    assign res_valid = (r_state == S_DONE);
    assign res_data  = r_res_data;
    assign res_zero  = r_res_zero;
    assign res_err   = r_res_err;

    // Signed less-than from A-B: the sign of the difference, corrected on overflow.
    assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) & (alu_out[WIDTH-1] != r_a[WIDTH-1]);
    assign w_lt  = alu_out[WIDTH-1] ^ w_ovf;

    always_comb begin
        w_legal  = 1'b1;
        w_is_mul = 1'b0;
        w_is_slt = 1'b0;
        w_ctrl   = C_ADD;
        case (in_aluop)
            2'b00: w_ctrl = C_ADD;
            2'b01: w_ctrl = C_SUB;
            2'b10: begin
                case (in_funct)
                    6'b100000: w_ctrl = C_ADD;
                    6'b100010: w_ctrl = C_SUB;
                    6'b100100: w_ctrl = C_AND;
                    6'b100101: w_ctrl = C_OR;
                    6'b101010: begin
                        w_ctrl   = C_SUB;
                        w_is_slt = 1'b1;
                    end
                    6'b011000: begin
                        w_is_mul = MUL_EN;
                        w_legal  = MUL_EN;
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        alu_ctrl    = C_AND;
        alu_op1     = '0;
        alu_op2     = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (!w_legal)     w_state_nxt = S_DONE;
                    else if (w_is_mul) w_state_nxt = S_MUL;
                    else              w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_ctrl    = r_ctrl;
                alu_op1     = r_a;
                alu_op2     = r_b;
                w_state_nxt = S_DONE;
            end
            S_MUL: begin
                alu_ctrl = C_ADD;
                alu_op1  = r_acc;
                alu_op2  = r_mplier[0] ? r_mcand : '0;
                if (r_cnt == C_CNT_LAST) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (res_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a        <= '0;
            r_b        <= '0;
            r_ctrl     <= C_AND;
            r_slt      <= 1'b0;
            r_acc      <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_res_data <= '0;
            r_res_zero <= 1'b0;
            r_res_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= in_a;
                        r_b      <= in_b;
                        r_ctrl   <= w_ctrl;
                        r_slt    <= w_is_slt;
                        r_acc    <= '0;
                        r_mcand  <= in_a;
                        r_mplier <= in_b;
                        r_cnt    <= '0;
                        r_res_err <= ~w_legal;
                        if (!w_legal) begin
                            r_res_data <= '0;
                            r_res_zero <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    if (r_slt) begin
                        r_res_data <= {{(WIDTH-1){1'b0}}, w_lt};
                        r_res_zero <= ~w_lt;
                    end else begin
                        r_res_data <= alu_out;
                        r_res_zero <= alu_zero;
                    end
                end
                S_MUL: begin
                    r_acc    <= alu_out;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == C_CNT_LAST) begin
                        r_res_data <= alu_out;
                        r_res_zero <= (alu_out == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
